ternary_mult_ctrl: RTL and testbench

TERNARY_MULT_CTRL -- requirements
Module: ternary_mult_ctrl

---
 rtl/ternary_mult_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ternary_mult_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_mult_ctrl.sv
// Sequences 8 load/issue steps into a ternary MAC datapath, then drains 8 result bytes.
// Optional build macro TERNARY_CHECK_EN: flags (sticky err) and zeroes illegal 2'b11 weights.
module ternary_mult_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [2:0]  row,
  output logic        en,
  output logic [15:0] vec_in,
  output logic [31:0] w_out,
  input  logic [7:0]  vec_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, CAPTURE, WAIT, DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  row_q;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [31:0] w_q, w_d;
  logic [31:0] w_eff;
  logic        done_q, done_d;
  logic        in_hs, out_hs;

`ifdef TERNARY_CHECK_EN
  logic [31:0] ill;
  logic        err_q;

  // low bit of every 2'b11 field, widened to cover both bits
  assign ill   = w_q & (w_q >> 1) & 32'h5555_5555;
  assign w_eff = w_q & ~(ill | (ill << 1));
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_hs && bcnt_q >= 3'd2 &&
                 |(in_data & (in_data >> 1) & 8'h55)) begin
      err_q <= 1'b1;
    end
  end
`else
  assign w_eff = w_q;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    bcnt_d    = bcnt_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    w_d       = w_q;
    done_d    = 1'b0;
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    out_data  = 8'h00;
    en        = 1'b0;
    vec_in    = 16'h0000;
    w_out     = 32'h0000_0000;
    row       = row_q;
    in_hs     = in_ready & in_valid;
    out_hs    = out_valid & out_ready;

    unique case (state_q)
      IDLE: begin
        row = 3'd0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (in_hs) begin
          unique case (bcnt_q)
            3'd0:    a_d = in_data;
            3'd1:    b_d = in_data;
            3'd2:    w_d[7:0]   = in_data;
            3'd3:    w_d[15:8]  = in_data;
            3'd4:    w_d[23:16] = in_data;
            3'd5:    w_d[31:24] = in_data;
            default: ;
          endcase
          if (bcnt_q == 3'd5) begin
            bcnt_d  = 3'd0;
            state_d = ISSUE;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      ISSUE: begin
        row     = step_q;
        vec_in  = {a_q, b_q};
        w_out   = w_eff;
        step_d  = step_q + 3'd1;
        state_d = (step_q == 3'd7) ? CAPTURE : LOAD;
      end
      CAPTURE: begin
        row     = 3'd0;
        en      = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        row     = 3'd0;
        state_d = DRAIN;
      end
      DRAIN: begin
        row      = k_q;
        out_data = vec_out;
        if (out_hs) begin
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      bcnt_q  <= 3'd0;
      k_q     <= 3'd0;
      row_q   <= 3'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      w_q     <= 32'h0000_0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      bcnt_q  <= bcnt_d;
      k_q     <= k_d;
      row_q   <= row;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_ternary_mult_ctrl.sv
// Directed bench for ternary_mult_ctrl with a behavioural ternary MAC datapath and result scoreboard.
// Honours TERNARY_CHECK_EN to select expectations for the illegal-weight pass.
module tb_ternary_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [2:0]  row;
  logic        en;
  logic [15:0] vec_in;
  logic [31:0] w_out;
  logic [7:0]  vec_out;
  logic        busy, done, err;

  ternary_mult_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .row(row), .en(en), .vec_in(vec_in), .w_out(w_out),
    .vec_out(vec_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_first, t_last;
  int xfers = 0;
  int done_cnt = 0;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Datapath: column c accumulates A*wA[c] + B*wB[c]; en snapshots and clears.
  logic [7:0] acc [8];
  logic [7:0] cap [8];

  function automatic logic [7:0] tmul(input logic [1:0] wt,
                                      input logic [7:0] x);
    if (wt[1]) return -x;
    else if (wt[0]) return x;
    else return 8'h00;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int c = 0; c < 8; c++) begin
      if (rst) begin
        acc[c] <= 8'h00;
        cap[c] <= 8'h00;
      end else if (en) begin
        cap[c] <= acc[c];
        acc[c] <= 8'h00;
      end else begin
        acc[c] <= acc[c] + tmul(w_out[2*c +: 2], vec_in[15:8])
                         + tmul(w_out[16 + 2*c +: 2], vec_in[7:0]);
      end
    end
  end

  assign vec_out = cap[row];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      xfers++;
      t_last = cyc + 1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk($sformatf("out_row%0d", row), {24'h0, out_data},
            {24'h0, sb.pop_front()});
      end
    end
    if (done) done_cnt++;
  end

  task automatic push8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) sb.push_back(v);
  endtask

  task automatic reset_vals(input string p);
    chk({p, "_row"}, {29'h0, row}, 32'd0);
    chk({p, "_en"}, {31'h0, en}, 32'd0);
    chk({p, "_vec_in"}, {16'h0, vec_in}, 32'd0);
    chk({p, "_w_out"}, w_out, 32'd0);
    chk({p, "_in_ready"}, {31'h0, in_ready}, 32'd0);
    chk({p, "_out_valid"}, {31'h0, out_valid}, 32'd0);
    chk({p, "_out_data"}, {24'h0, out_data}, 32'd0);
    chk({p, "_busy"}, {31'h0, busy}, 32'd0);
    chk({p, "_done"}, {31'h0, done}, 32'd0);
    chk({p, "_err"}, {31'h0, err}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1;
        @(posedge clk); #1;
        if (t_first < 0) t_first = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    t_first = -1;
    xfers   = 0;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    chk("busy_after_start", {31'h0, busy}, 32'd1);
  endtask

  task automatic run_load(input logic [7:0] a, input logic [7:0] b,
                          input logic [31:0] w, input logic [31:0] w_exp,
                          input bit ramp, input bit poke);
    logic [7:0] as;
    for (int s = 0; s < 8; s++) begin
      as = ramp ? 8'(s) : a;
      if (poke && s == 2) start = 1'b1;
      send_byte(as);
      start = 1'b0;
      send_byte(b);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
      chk($sformatf("issue%0d_row", s), {29'h0, row}, 32'(s));
      chk($sformatf("issue%0d_vec", s), {16'h0, vec_in}, {16'h0, as, b});
      chk($sformatf("issue%0d_w", s), w_out, w_exp);
      chk($sformatf("issue%0d_en", s), {31'h0, en}, 32'd0);
    end
  endtask

  task automatic wait_done(input int base);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", {31'h0, seen}, 32'd1);
    chk("busy_at_done", {31'h0, busy}, 32'd0);
    chk("row_idle", {29'h0, row}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'h0, done}, 32'd0);
    chk("done_count", 32'(done_cnt - base), 32'd1);
    chk("xfers", 32'(xfers), 32'd8);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit found;
    logic [31:0] wff_exp;
    logic [7:0]  rff_exp;
    logic        err_exp;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_vals("rst");
    rst = 1'b0;
    out_ready = 1'b1;

    // all +1 weights
    base = done_cnt;
    push8(8'h18);
    pulse_start();
    run_load(8'd1, 8'd2, 32'h5555_5555, 32'h5555_5555, 0, 0);
    wait_done(base);
    chk("latency", 32'(t_last - t_first + 1), 32'd66);

    // all -1 weights
    base = done_cnt;
    push8(8'hE0);
    pulse_start();
    run_load(8'd3, 8'd1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 0, 0);
    wait_done(base);

    // A ramps with step: 0+1+..+7 = 28
    base = done_cnt;
    push8(8'h1C);
    pulse_start();
    run_load(8'd0, 8'd0, 32'h5555_5555, 32'h5555_5555, 1, 0);
    wait_done(base);

    // column 0 = +1, column 1 = -1, others zero
    base = done_cnt;
    sb.push_back(8'h18);
    sb.push_back(8'hE8);
    for (int i = 0; i < 6; i++) sb.push_back(8'h00);
    pulse_start();
    run_load(8'd3, 8'd0, 32'h0000_0009, 32'h0000_0009, 0, 0);
    wait_done(base);

    // output stall at row 3, stray start / in_valid during LOAD and DRAIN
    base = done_cnt;
    push8(8'h18);
    pulse_start();
    run_load(8'd1, 8'd2, 32'h5555_5555, 32'h5555_5555, 0, 1);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_valid && row == 3'd3) begin
        found = 1;
        break;
      end
    end
    chk("stall_reach_row3", {31'h0, found}, 32'd1);
    out_ready = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_row", i), {29'h0, row}, 32'd3);
      chk($sformatf("stall%0d_data", i), {24'h0, out_data}, 32'h18);
      chk($sformatf("stall%0d_valid", i), {31'h0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_inrdy", i), {31'h0, in_ready}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done(base);

    // reset after 20 bytes abandons the pass
    base = done_cnt;
    pulse_start();
    for (int s = 0; s < 4; s++) begin
      send_byte(8'd1);
      send_byte(8'd2);
      if (s < 3) begin
        for (int j = 0; j < 4; j++) send_byte(8'h55);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    reset_vals("midrst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart_busy", {31'h0, busy}, 32'd0);
    chk("no_done_on_rst", 32'(done_cnt - base), 32'd0);
    push8(8'h18);
    pulse_start();
    run_load(8'd1, 8'd2, 32'h5555_5555, 32'h5555_5555, 0, 0);
    wait_done(base);

    // illegal 2'b11 weights
`ifdef TERNARY_CHECK_EN
    wff_exp = 32'h0000_0000;
    rff_exp = 8'h00;
    err_exp = 1'b1;
`else
    wff_exp = 32'hFFFF_FFFF;
    rff_exp = 8'hE8;
    err_exp = 1'b0;
`endif
    base = done_cnt;
    push8(rff_exp);
    pulse_start();
    run_load(8'd1, 8'd2, 32'hFFFF_FFFF, wff_exp, 0, 0);
    wait_done(base);
    chk("err_flag", {31'h0, err}, {31'h0, err_exp});
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", {31'h0, err}, {31'h0, err_exp});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
